// File: rtl/lcd_write_arbiter.sv
// Two-requester packet arbiter and pacing sequencer for the LCD character-write port.
// Optional stall timeout is enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_write_arbiter #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       req0_valid,
   input  logic       req0_row,
   input  logic [3:0] req0_col,
   input  logic [7:0] req0_char,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic       req1_row,
   input  logic [3:0] req1_col,
   input  logic [7:0] req1_char,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic       lcd_row,
   output logic [3:0] lcd_col,
   output logic [7:0] lcd_char,
   output logic       lcd_we,
   input  logic       lcd_busy,
   output logic [1:0] grant,
   output logic       done,
   output logic       abort
);

   typedef enum logic [2:0] {IDLE, ISSUE, WE, BLANK, WAIT} state_t;

   state_t     state, state_nx;
   logic [1:0] grant_nx;
   logic       ptr, ptr_nx;        // 1 = req1 served last
   logic       last_q;
   logic       sel_valid, sel_row, sel_last;
   logic [3:0] sel_col;
   logic [7:0] sel_char;
   logic       accept;
   logic       timeout_hit;

   always_comb begin
      sel_valid = (grant[0] & req0_valid) | (grant[1] & req1_valid);
      sel_row   = grant[1] ? req1_row  : req0_row;
      sel_col   = grant[1] ? req1_col  : req0_col;
      sel_char  = grant[1] ? req1_char : req0_char;
      sel_last  = grant[1] ? req1_last : req0_last;
   end

   assign accept     = (state == ISSUE) && sel_valid && !lcd_busy;
   assign req0_ready = accept & grant[0];
   assign req1_ready = accept & grant[1];

`ifdef LCD_ARB_TIMEOUT_EN
   logic [15:0] stall_cnt;

   assign timeout_hit = (state == ISSUE) && !sel_valid && (stall_cnt == 16'(TIMEOUT - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         stall_cnt <= '0;
      end else if (state != ISSUE || accept) begin
         stall_cnt <= '0;
      end else if (!sel_valid) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`else
   logic [15:0] unused_timeout;

   assign unused_timeout = 16'(TIMEOUT);
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      grant_nx = grant;
      ptr_nx   = ptr;
      lcd_we   = 1'b0;
      done     = 1'b0;
      abort    = 1'b0;
      case (state)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               // on a tie the requester not served last wins
               if (req0_valid && req1_valid) grant_nx = ptr ? 2'b01 : 2'b10;
               else                          grant_nx = {req1_valid, req0_valid};
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            if (accept) begin
               state_nx = WE;
            end else if (timeout_hit) begin
               abort    = 1'b1;
               ptr_nx   = grant[1];
               grant_nx = '0;
               state_nx = IDLE;
            end
         end
         WE: begin
            lcd_we   = 1'b1;
            state_nx = BLANK;
         end
         BLANK: state_nx = WAIT;
         WAIT: begin
            if (!lcd_busy) begin
               if (last_q) begin
                  done     = 1'b1;
                  ptr_nx   = grant[1];
                  grant_nx = '0;
                  state_nx = IDLE;
               end else begin
                  state_nx = ISSUE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         grant    <= '0;
         ptr      <= 1'b1;
         last_q   <= 1'b0;
         lcd_row  <= 1'b0;
         lcd_col  <= '0;
         lcd_char <= '0;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         ptr   <= ptr_nx;
         if (accept) begin
            lcd_row  <= sel_row;
            lcd_col  <= sel_col;
            lcd_char <= sel_char;
            last_q   <= sel_last;
         end
      end
   end

endmodule
